// File: rtl/corelet_ctrl.sv
// corelet_ctrl: corelet instruction/address sequencer for one tile; CTRL_PERF_CNT_EN adds stall_cnt/cycle_cnt
module corelet_ctrl #(
    parameter int row = 8,
    parameter int col = 8,
    parameter int len_bw = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [len_bw-1:0] len,
    input  logic              acc_en,
    input  logic              l0_full,
    input  logic              ofifo_valid,
    output logic [34:0]       inst,
    output logic              xmem_cen,
    output logic [len_bw-1:0] xmem_addr,
    output logic              pmem_wen,
    output logic [len_bw-1:0] pmem_addr,
    output logic              busy,
    output logic              done
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       cycle_cnt
`endif
);
    typedef enum logic [2:0] {IDLE, WLOAD, KLOAD, ACT, EXEC, DRAIN, READ, DONE} state_t;
    localparam logic [len_bw-1:0] n_row = len_bw'(row);
    localparam logic [len_bw-1:0] n_rc = len_bw'(row + col);
    state_t state, ns;
    logic [len_bw-1:0] cnt, cnt_n, len_r;
    logic mode_r, acc_r, mode_n, acc_n, go, act, stall;
    logic [34:0] inst_n;
    // cnt holds the number of phase actions issued so far, including the current cycle;
    // every output is computed one edge ahead from the state being entered (ns)
    always_comb begin
        go = state == IDLE && start;
        mode_n = go ? mode : mode_r;
        acc_n = go ? acc_en : acc_r;
        ns = state;
        case (state)
            IDLE:  ns = start ? WLOAD : IDLE;
            WLOAD: if (cnt == n_row) ns = mode_r ? (len_r == '0 ? DONE : ACT) : KLOAD;
            KLOAD: if (cnt == n_rc) ns = len_r == '0 ? DONE : ACT;
            ACT:   if (cnt == len_r) ns = EXEC;
            EXEC:  if (cnt == len_r) ns = DRAIN;
            DRAIN: if (cnt == n_rc) ns = READ;
            READ:  if (cnt == len_r) ns = DONE;
            DONE:  ns = IDLE;
        endcase
        stall = ((ns == WLOAD || ns == ACT) && l0_full) || (ns == READ && !ofifo_valid);
        act = (ns inside {KLOAD, EXEC, DRAIN}) || ((ns inside {WLOAD, ACT, READ}) && !stall);
        cnt_n = (ns == state ? cnt : '0) + len_bw'(act);
        inst_n = '0;
        inst_n[34] = ns != IDLE && mode_n;
        inst_n[33] = ns == READ && acc_n;
        inst_n[6] = ns == READ && act;
        inst_n[5] = ns == EXEC && mode_n;
        inst_n[4] = ns == WLOAD && act && mode_n;
        inst_n[3] = ns == KLOAD || ns == EXEC;
        inst_n[2] = (ns == WLOAD && act && !mode_n) || (ns == ACT && act);
        inst_n[1] = ns == EXEC;
        inst_n[0] = ns == KLOAD;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            len_r <= '0;
            mode_r <= 1'b0;
            acc_r <= 1'b0;
            inst <= '0;
            xmem_cen <= 1'b1;
            xmem_addr <= '0;
            pmem_wen <= 1'b1;
            pmem_addr <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= ns;
            cnt <= cnt_n;
            mode_r <= mode_n;
            acc_r <= acc_n;
            if (go) len_r <= len;
            inst <= inst_n;
            xmem_cen <= !(inst_n[2] || inst_n[4]);
            xmem_addr <= ns == DONE ? '0 : xmem_addr + len_bw'(!xmem_cen);
            pmem_wen <= !inst_n[6];
            pmem_addr <= pmem_addr + len_bw'(!pmem_wen);
            busy <= ns != IDLE;
            done <= ns == DONE;
        end
    end
`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            cycle_cnt <= '0;
        end else begin
            stall_cnt <= (go ? '0 : stall_cnt) + 32'(stall);
            cycle_cnt <= (go ? '0 : cycle_cnt) + 32'(ns != IDLE);
        end
    end
`endif
endmodule

// File: tb/tb_corelet_ctrl.sv
// tb_corelet_ctrl: randomized self-checking bench for corelet_ctrl against a per-cycle run model
module tb_corelet_ctrl;
    localparam int row = 8, col = 8, bw = 11;
    logic clk = 1'b0, reset, start, mode, acc_en, l0_full, ofifo_valid;
    logic [bw-1:0] len, xmem_addr, pmem_addr;
    logic [34:0] inst;
    logic xmem_cen, pmem_wen, busy, done;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] stall_cnt, cycle_cnt;
`endif
    int checks = 0, errors = 0;
    logic [bw-1:0] pbase = '0;
    typedef struct packed {
        logic [34:0] inst;
        logic cen;
        logic [bw-1:0] xa;
        logic wen;
        logic [bw-1:0] pa;
        logic busy;
        logic done;
    } smp_t;
    smp_t tr[$];
    smp_t ex[$];

    always #5 clk = ~clk;

    corelet_ctrl #(.row(row), .col(col), .len_bw(bw)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .len(len), .acc_en(acc_en),
        .l0_full(l0_full), .ofifo_valid(ofifo_valid), .inst(inst), .xmem_cen(xmem_cen),
        .xmem_addr(xmem_addr), .pmem_wen(pmem_wen), .pmem_addr(pmem_addr), .busy(busy), .done(done)
`ifdef CTRL_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .cycle_cnt(cycle_cnt)
`endif
    );

    function automatic smp_t cur();
        return '{inst, xmem_cen, xmem_addr, pmem_wen, pmem_addr, busy, done};
    endfunction

    // Expected cycle-by-cycle trace of a stall-free run, straight from the phase rules
    function automatic void build(input logic m, input int n, input logic a);
        logic [34:0] mb;
        mb = '0;
        mb[34] = m;
        ex.delete();
        for (int i = 0; i < row; i++)
            ex.push_back('{mb | (m ? 35'h10 : 35'h4), 1'b0, bw'(i), 1'b1, pbase, 1'b1, 1'b0});
        if (!m) for (int i = 0; i < row + col; i++)
            ex.push_back('{mb | 35'h9, 1'b1, bw'(row), 1'b1, pbase, 1'b1, 1'b0});
        if (n > 0) begin
            for (int i = 0; i < n; i++)
                ex.push_back('{mb | 35'h4, 1'b0, bw'(row + i), 1'b1, pbase, 1'b1, 1'b0});
            for (int i = 0; i < n; i++)
                ex.push_back('{mb | 35'hA | (m ? 35'h20 : 35'h0), 1'b1, bw'(row + n), 1'b1, pbase, 1'b1, 1'b0});
            for (int i = 0; i < row + col; i++)
                ex.push_back('{mb, 1'b1, bw'(row + n), 1'b1, pbase, 1'b1, 1'b0});
            for (int i = 0; i < n; i++)
                ex.push_back('{mb | 35'h40 | {a, 33'b0}, 1'b1, bw'(row + n), 1'b0, pbase + bw'(i), 1'b1, 1'b0});
        end
        ex.push_back('{mb, 1'b1, bw'(0), 1'b1, pbase + bw'(n), 1'b1, 1'b1});
    endfunction

    // l0m: 0 none, 1 random, 2 three-cycle pulse mid-ACT; ofm: 0 always valid, 1 toggle, 2 random
    task automatic run(input logic m, input int n, input logic a, input int l0m, input int ofm, input bit kick);
        int pulse = 0;
        bit pulsed = 0, kicked = 0;
        tr.delete();
        @(negedge clk);
        start = 1'b1; mode = m; len = bw'(n); acc_en = a; l0_full = 1'b0; ofifo_valid = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start = 1'b0; mode = 1'($urandom); len = bw'($urandom); acc_en = 1'($urandom);
            tr.push_back(cur());
            if (done) break;
            l0_full = l0m == 1 ? ($urandom_range(0, 2) == 0) : 1'b0;
            if (l0m == 2 && !pulsed && !xmem_cen && xmem_addr == bw'(row + 2)) begin
                pulsed = 1;
                pulse = 3;
            end
            if (pulse > 0) begin
                l0_full = 1'b1;
                pulse--;
            end
            ofifo_valid = ofm == 0 ? 1'b1 : ofm == 1 ? ~ofifo_valid : 1'($urandom_range(0, 1));
            if (kick && !kicked && !pmem_wen) begin
                start = 1'b1;
                kicked = 1;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL run_timeout: done=%0b after %0d cycles, expected 1", done, tr.size());
        end
        l0_full = 1'b0;
        ofifo_valid = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; mode = 1'b0; len = bw'(2); acc_en = 1'b0;
        l0_full = 1'b0; ofifo_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (inst !== '0 || busy !== 1'b0 || done !== 1'b0 || xmem_cen !== 1'b1 || pmem_wen !== 1'b1
                || xmem_addr !== '0 || pmem_addr !== '0) begin
                errors++;
                $display("FAIL reset_state: inst=%h busy=%b done=%b cen=%b wen=%b xa=%0d pa=%0d, expected 0/0/0/1/1/0/0",
                         inst, busy, done, xmem_cen, pmem_wen, xmem_addr, pmem_addr);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || inst !== 35'h4 || xmem_cen !== 1'b0 || xmem_addr !== '0) begin
            errors++;
            $display("FAIL reset_release_start: busy=%b inst=%h cen=%b xa=%0d, expected 1/004/0/0",
                     busy, inst, xmem_cen, xmem_addr);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pbase = '0;
    endtask

    task automatic test_model();
        logic m_t[6];
        logic a_t[6];
        int n_t[6];
        m_t = '{1'b0, 1'b1, 1'b0, 1'b1, 1'($urandom), 1'($urandom)};
        a_t = '{1'b0, 1'b1, 1'b0, 1'b1, 1'($urandom), 1'($urandom)};
        n_t = '{16, 4, 0, 0, $urandom_range(1, 30), $urandom_range(1, 30)};
        for (int k = 0; k < 6; k++) begin
            build(m_t[k], n_t[k], a_t[k]);
            run(m_t[k], n_t[k], a_t[k], 0, 0, 0);
            checks++;
            if (tr.size() != ex.size()) begin
                errors++;
                $display("FAIL model_length cfg%0d: got %0d cycles, expected %0d", k, tr.size(), ex.size());
            end
            for (int i = 0; i < tr.size() && i < ex.size(); i++) begin
                bit bad;
                bad = tr[i].inst !== ex[i].inst || tr[i].cen !== ex[i].cen || tr[i].wen !== ex[i].wen
                      || tr[i].busy !== ex[i].busy || tr[i].done !== ex[i].done
                      || ((!ex[i].cen || ex[i].done) && tr[i].xa !== ex[i].xa)
                      || ((!ex[i].wen || ex[i].done) && tr[i].pa !== ex[i].pa);
                checks++;
                if (bad) begin
                    errors++;
                    $display("FAIL model cfg%0d cycle %0d: got %h, expected %h", k, i, tr[i], ex[i]);
                end
            end
            pbase = pbase + bw'(n_t[k]);
        end
    endtask

    task automatic test_l0_stall();
        int n = 10, last_k = -1, first_e = -1, stalls = 0, nw = 0, bad_frz = 0;
        run(1'b0, n, 1'b0, 2, 0, 0);
        for (int i = 0; i < tr.size(); i++) begin
            if (tr[i].inst[0]) last_k = i;
            if (tr[i].inst[1] && first_e < 0) first_e = i;
            if (!tr[i].cen) begin
                checks++;
                if (tr[i].xa !== bw'(nw) || !tr[i].inst[2]) begin
                    errors++;
                    $display("FAIL l0_write_order: write %0d at xa=%0d wr=%b, expected xa=%0d wr=1", nw, tr[i].xa, tr[i].inst[2], nw);
                end
                nw++;
            end
        end
        for (int i = last_k + 1; i >= 1 && i < first_e; i++) if (tr[i].cen) begin
            stalls++;
            if (tr[i].inst[2] || tr[i].xa !== tr[i+1].xa) bad_frz++;
        end
        checks++;
        if (first_e - last_k - 1 != n + 3 || stalls != 3 || bad_frz != 0) begin
            errors++;
            $display("FAIL l0_stall_act: act_cycles=%0d stalls=%0d unfrozen=%0d, expected %0d/3/0",
                     first_e - last_k - 1, stalls, bad_frz, n + 3);
        end
        checks++;
        if (nw != row + n) begin
            errors++;
            $display("FAIL l0_write_count: got %0d, expected %0d", nw, row + n);
        end
        pbase = pbase + bw'(n);
    endtask

    task automatic test_read_toggle();
        int n = 8, rd = 0, wr = 0, dn = 0, incoh = 0;
        run(1'b0, n, 1'b1, 0, 1, 1);
        foreach (tr[i]) begin
            if (tr[i].inst[6]) rd++;
            if (tr[i].done) dn++;
            if (tr[i].inst[6] !== !tr[i].wen) incoh++;
            if (!tr[i].wen) begin
                checks++;
                if (tr[i].pa !== pbase + bw'(wr) || !tr[i].inst[33]) begin
                    errors++;
                    $display("FAIL read_addr: pa=%0d acc=%b, expected pa=%0d acc=1", tr[i].pa, tr[i].inst[33], pbase + bw'(wr));
                end
                wr++;
            end
        end
        checks++;
        if (rd != n || wr != n || dn != 1 || incoh != 0) begin
            errors++;
            $display("FAIL read_counts: rd=%0d wen=%0d done=%0d incoherent=%0d, expected %0d/%0d/1/0", rd, wr, dn, incoh, n, n);
        end
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL read_start_ignored: busy=%b after done, expected 0", busy);
            end
        end
        pbase = pbase + bw'(n);
    endtask

    task automatic test_reset_exec();
        int c = 0;
        @(negedge clk);
        start = 1'b1; mode = 1'b0; len = bw'(12); acc_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (!inst[1] && c < 200) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (!inst[1]) begin
            errors++;
            $display("FAIL exec_reached: inst[1]=%b, expected 1", inst[1]);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (inst !== '0 || xmem_cen !== 1'b1 || busy !== 1'b0 || xmem_addr !== '0 || pmem_addr !== '0 || pmem_wen !== 1'b1) begin
            errors++;
            $display("FAIL reset_exec: inst=%h cen=%b busy=%b xa=%0d pa=%0d wen=%b, expected 0/1/0/0/0/1",
                     inst, xmem_cen, busy, xmem_addr, pmem_addr, pmem_wen);
        end
        reset = 1'b0;
        pbase = '0;
        run(1'b1, 5, 1'b0, 0, 0, 0);
        checks++;
        if (tr.size() < 2 || tr[0].cen !== 1'b0 || tr[0].xa !== '0 || tr[1].xa !== bw'(1) || tr[0].inst !== 35'h400000010) begin
            errors++;
            $display("FAIL restart_clean: first=%h, expected inst=400000010 cen=0 xa=0 then xa=1", tr[0]);
        end
        pbase = pbase + bw'(5);
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            logic m, a;
            int n, nw, nr, nk, ne, n5, bad34, dn;
            m = 1'($urandom); a = 1'($urandom); n = $urandom_range(1, 24);
            nw = 0; nr = 0; nk = 0; ne = 0; n5 = 0; bad34 = 0; dn = 0;
            run(m, n, a, 1, 2, 0);
            foreach (tr[i]) begin
                if (!tr[i].cen && tr[i].xa === bw'(nw)) nw++;
                else if (!tr[i].cen) nw += 1000;
                if (!tr[i].wen && tr[i].pa === pbase + bw'(nr)) nr++;
                else if (!tr[i].wen) nr += 1000;
                nk += int'(tr[i].inst[0]);
                ne += int'(tr[i].inst[1]);
                n5 += int'(tr[i].inst[5]);
                dn += int'(tr[i].done);
                if (tr[i].inst[34] !== m) bad34++;
            end
            checks++;
            if (nw != row + n || nr != n || nk != (m ? 0 : row + col) || ne != n || n5 != (m ? n : 0) || dn != 1 || bad34 != 0) begin
                errors++;
                $display("FAIL random%0d m=%0b len=%0d: wr=%0d rd=%0d kl=%0d ex=%0d if=%0d done=%0d bad_mode=%0d, expected %0d/%0d/%0d/%0d/%0d/1/0",
                         k, m, n, nw, nr, nk, ne, n5, dn, bad34, row + n, n, m ? 0 : row + col, n, m ? n : 0);
            end
`ifdef CTRL_PERF_CNT_EN
            checks++;
            if (cycle_cnt !== 32'(tr.size())) begin
                errors++;
                $display("FAIL perf_cycle_cnt: got %0d, expected %0d", cycle_cnt, tr.size());
            end
`endif
            pbase = pbase + bw'(n);
        end
    endtask

    initial begin
        test_reset();
        test_model();
        test_l0_stall();
        test_read_toggle();
        test_reset_exec();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
